// File: rtl/life_game_step.sv
// In-place Game of Life generation engine over a 64x64 grid in block memory.
// Define LIFE_STEP_WRAP_EN for a toroidal grid; otherwise cells past the edges are dead.
module life_game_step #(
  parameter logic [8:0] RULE_BIRTH   = 9'b000001000,
  parameter logic [8:0] RULE_SURVIVE = 9'b000001100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count,
  output logic        mem_req,
  output logic [6:0]  mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_we,
  output logic [31:0] mem_wr_data
);

`ifdef LIFE_STEP_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, WR_LO, WR_HI, RD_LO, RD_HI, SHIFT, DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  lc;
  logic [5:0]  row;
  logic [63:0] prev_r, cur_r, next_r;
  logic [63:0] save0, save1;
  logic [31:0] nlo;
  logic [15:0] gen_q;
  logic [63:0] new_row;
  logic [65:0] pe, ce, ne;

  function automatic logic cell_next(
    input logic [2:0] p,
    input logic [2:0] c,
    input logic [2:0] n
  );
    logic [3:0] cnt;
    cnt = {3'b0, p[0]} + {3'b0, p[1]} + {3'b0, p[2]}
        + {3'b0, c[0]} + {3'b0, c[2]}
        + {3'b0, n[0]} + {3'b0, n[1]} + {3'b0, n[2]};
    return c[1] ? RULE_SURVIVE[cnt] : RULE_BIRTH[cnt];
  endfunction

  // Next generation of the current row from the three buffered rows
  always_comb begin
    pe = {WRAP & prev_r[0], prev_r, WRAP & prev_r[63]};
    ce = {WRAP & cur_r[0], cur_r, WRAP & cur_r[63]};
    ne = {WRAP & next_r[0], next_r, WRAP & next_r[63]};
    new_row = '0;
    for (int c = 0; c < 64; c++)
      new_row[c] = cell_next(pe[c +: 3], ce[c +: 3], ne[c +: 3]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and memory port drive
  always_comb begin
    state_nx    = state;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (lc < 3'd6) mem_addr = 7'd126 + {4'd0, lc};
        if (lc == 3'd6) state_nx = WR_LO;
      end
      WR_LO: begin
        mem_addr    = {row, 1'b0};
        mem_we      = 1'b1;
        mem_wr_data = new_row[31:0];
        state_nx    = WR_HI;
      end
      WR_HI: begin
        mem_addr    = {row, 1'b1};
        mem_we      = 1'b1;
        mem_wr_data = new_row[63:32];
        state_nx    = RD_LO;
      end
      RD_LO: begin
        if (row < 6'd62) mem_addr = {row + 6'd2, 1'b0};
        state_nx = RD_HI;
      end
      RD_HI: begin
        if (row < 6'd62) mem_addr = {row + 6'd2, 1'b1};
        state_nx = SHIFT;
      end
      SHIFT: state_nx = (row == 6'd63) ? DONE : WR_LO;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Row buffers, counters and saved top rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lc     <= '0;
      row    <= '0;
      prev_r <= '0;
      cur_r  <= '0;
      next_r <= '0;
      save0  <= '0;
      save1  <= '0;
      nlo    <= '0;
      gen_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          lc  <= '0;
          row <= '0;
        end
        LOAD: begin
          lc <= lc + 3'd1;
          unique case (lc)
            3'd1: prev_r[31:0]  <= WRAP ? mem_rd_data : '0;
            3'd2: prev_r[63:32] <= WRAP ? mem_rd_data : '0;
            3'd3: begin
              cur_r[31:0] <= mem_rd_data;
              save0[31:0] <= mem_rd_data;
            end
            3'd4: begin
              cur_r[63:32] <= mem_rd_data;
              save0[63:32] <= mem_rd_data;
            end
            3'd5: begin
              next_r[31:0] <= mem_rd_data;
              save1[31:0]  <= mem_rd_data;
            end
            3'd6: begin
              next_r[63:32] <= mem_rd_data;
              save1[63:32]  <= mem_rd_data;
            end
            default: ;
          endcase
        end
        RD_HI: nlo <= mem_rd_data;
        SHIFT: begin
          prev_r <= cur_r;
          cur_r  <= next_r;
          if (row == 6'd62)      next_r <= WRAP ? save0 : '0;
          else if (row == 6'd63) next_r <= WRAP ? save1 : '0;
          else                   next_r <= {mem_rd_data, nlo};
          row <= row + 6'd1;
          if (row == 6'd63) gen_q <= gen_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign mem_req   = busy;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_game_step.sv
// Directed bench for life_game_step with a behavioural block memory.
// Expected grids are hand-computed for the blinker, block and edge cases.
module tb_life_game_step;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_req, mem_we;
  logic [15:0] gen_count;
  logic [6:0]  mem_addr;
  logic [31:0] mem_rd_data, mem_wr_data;

  logic [31:0] mem [0:127];
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int viol = 0;

  life_game_step dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .gen_count(gen_count), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_we(mem_we), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rd_data <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_req !== busy) viol <= viol + 1;
    if (!busy && (mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wr_data !== 32'd0))
      viol <= viol + 1;
  end

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_gen(output int cyc, output logic dn, output logic [15:0] gc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    dn = done;
    gc = gen_count;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, mem_req, mem_we} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, done, mem_req, mem_we});
    end
    tests++;
    if (mem_addr !== 7'd0 || mem_wr_data !== 32'd0 || gen_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_data addr=%0d wd=%h gc=%0d want 0", mem_addr, mem_wr_data, gen_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blinker();
    int cyc, w0;
    logic dn;
    logic [15:0] gc;
    logic [31:0] exp;
    do_reset();
    clear_mem();
    mem[20] = 32'h0000_0070;
    w0 = wr_cnt;
    run_gen(cyc, dn, gc);
    tests++;
    if (cyc !== 327) begin
      fails++;
      $display("FAIL blinker_busy got %0d want 327", cyc);
    end
    tests++;
    if (dn !== 1'b1 || gc !== 16'd1) begin
      fails++;
      $display("FAIL blinker_done done=%b gc=%0d want 1 1", dn, gc);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
    end
    tests++;
    if (wr_cnt - w0 !== 128) begin
      fails++;
      $display("FAIL write_count got %0d want 128", wr_cnt - w0);
    end
    for (int i = 0; i < 128; i++) begin
      exp = (i == 18 || i == 20 || i == 22) ? 32'h0000_0020 : 32'd0;
      tests++;
      if (mem[i] !== exp) begin
        fails++;
        $display("FAIL blinker_word%0d got %h want %h", i, mem[i], exp);
      end
    end
  endtask

  task automatic test_block();
    int cyc;
    logic dn;
    logic [15:0] gc;
    do_reset();
    clear_mem();
    mem[10] = 32'h0000_0C00;
    mem[12] = 32'h0000_0C00;
    run_gen(cyc, dn, gc);
    @(negedge clk);
    run_gen(cyc, dn, gc);
    tests++;
    if (cyc !== 327 || gc !== 16'd2) begin
      fails++;
      $display("FAIL block_gen cyc=%0d gc=%0d want 327 2", cyc, gc);
    end
    tests++;
    if (mem[10] !== 32'h0000_0C00 || mem[12] !== 32'h0000_0C00 ||
        mem[11] !== 32'd0 || mem[13] !== 32'd0 || mem[8] !== 32'd0 || mem[14] !== 32'd0) begin
      fails++;
      $display("FAIL block_still w10=%h w12=%h want 00000c00", mem[10], mem[12]);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic dn;
    logic [15:0] gc;
    logic [31:0] exp3;
`ifdef LIFE_STEP_WRAP_EN
    exp3 = 32'h8000_0000;
`else
    exp3 = 32'd0;
`endif
    do_reset();
    clear_mem();
    mem[0] = 32'h1;
    mem[2] = 32'h1;
    mem[4] = 32'h1;
    run_gen(cyc, dn, gc);
    tests++;
    if (mem[2] !== 32'h3 || mem[3] !== exp3) begin
      fails++;
      $display("FAIL wrap_row1 w2=%h w3=%h want 00000003 %h", mem[2], mem[3], exp3);
    end
    tests++;
    if (mem[0] !== 32'd0 || mem[4] !== 32'd0 || mem[126] !== 32'd0 || mem[127] !== 32'd0) begin
      fails++;
      $display("FAIL wrap_edges w0=%h w4=%h w126=%h want 0", mem[0], mem[4], mem[126]);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    do_reset();
    clear_mem();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      cyc++;
      start = (cyc == 100);
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (cyc !== 327 || gen_count !== 16'd1) begin
      fails++;
      $display("FAIL start_ignored cyc=%0d gc=%0d want 327 1", cyc, gen_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || gen_count !== 16'd1) begin
      fails++;
      $display("FAIL start_ignored_idle busy=%b gc=%0d want 0 1", busy, gen_count);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, w0;
    logic dn;
    logic [15:0] gc;
    do_reset();
    clear_mem();
    mem[20] = 32'h0000_0070;
    run_gen(cyc, dn, gc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || gen_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid busy=%b we=%b gc=%0d want 0 0 0", busy, mem_we, gen_count);
    end
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (wr_cnt !== w0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet writes=%0d busy=%b want 0 0", wr_cnt - w0, busy);
    end
    run_gen(cyc, dn, gc);
    tests++;
    if (cyc !== 327 || dn !== 1'b1 || gc !== 16'd1) begin
      fails++;
      $display("FAIL reset_mid_rerun cyc=%0d done=%b gc=%0d want 327 1 1", cyc, dn, gc);
    end
  endtask

  task automatic test_port_rules();
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL idle_outputs got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_port_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
